// File: rtl/compare_result_monitor.sv
// ---------------------------------------------------------------------------
// compare_result_monitor
//
// Watches the equality result coming out of the upstream E/F compare pipeline
// and keeps running statistics:
//   - match_cnt / mismatch_cnt : saturating sample counters
//   - run_len                  : current streak of consecutive mismatches
//   - fail                     : sticky flag once the streak reaches FAIL_THRESH
//
// After start, the first WARMUP_CYCLES cycles are spent in WARMUP so that
// stale results still draining out of the pipeline are not counted.
//
// Counts accumulate across runs; only clear or rst_n zero them. Once in FAIL
// everything is frozen until clear or rst_n.
//
// Optional feature (macro MON_HISTORY_EN):
//   adds output hist[7:0], a shift register of the last eight MONITOR samples
//   (newest in bit 0), cleared by clear or rst_n.
//
// State table
//   state   | meaning
//   IDLE    | waiting for start, counts held
//   WARMUP  | pipeline filling, eq_in ignored, warm-up counter running down
//   MONITOR | eq_in sampled every cycle
//   FAIL    | consecutive-mismatch limit hit, everything frozen
// ---------------------------------------------------------------------------
module compare_result_monitor #(
    parameter int unsigned WARMUP_CYCLES = 3,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned FAIL_THRESH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             eq_in,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [3:0]       run_len,
    output logic             fail,
    output logic             busy,
    output logic [1:0]       state
`ifdef MON_HISTORY_EN
    ,
    output logic [7:0]       hist
`endif
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_WARMUP  = 2'b01;
    localparam logic [1:0] ST_MONITOR = 2'b10;
    localparam logic [1:0] ST_FAIL    = 2'b11;

    // Warm-up counter is only as wide as the configured warm-up length needs.
    localparam int unsigned WU_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES + 1) : 1;
    localparam logic [WU_W-1:0]  WU_LOAD  = WU_W'(WARMUP_CYCLES);
    localparam logic [WU_W-1:0]  WU_ONE   = WU_W'(1);
    localparam logic [3:0]       RUN_MAX  = 4'(FAIL_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q,    state_d;
    logic [WU_W-1:0]  wu_cnt_q,   wu_cnt_d;
    logic [CNT_W-1:0] match_q,    match_d;
    logic [CNT_W-1:0] mismatch_q, mismatch_d;
    logic [3:0]       run_q,      run_d;
    logic             fail_q,     fail_d;
    logic             busy_q,     busy_d;

    // High on cycles where eq_in is actually taken as a MONITOR sample.
    logic             sample_en;

    // Next-state and counter update; clear beats stop, stop beats FSM advance.
    always_comb begin
        state_d    = state_q;
        wu_cnt_d   = wu_cnt_q;
        match_d    = match_q;
        mismatch_d = mismatch_q;
        run_d      = run_q;
        fail_d     = fail_q;
        sample_en  = 1'b0;

        if (clear) begin
            state_d    = ST_IDLE;
            wu_cnt_d   = '0;
            match_d    = '0;
            mismatch_d = '0;
            run_d      = '0;
            fail_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // Counts carry over between runs; only the streak restarts.
                        run_d = '0;
                        if (WARMUP_CYCLES == 0) begin
                            state_d  = ST_MONITOR;
                            wu_cnt_d = '0;
                        end else begin
                            state_d  = ST_WARMUP;
                            wu_cnt_d = WU_LOAD;
                        end
                    end
                end

                ST_WARMUP: begin
                    if (stop) begin
                        state_d  = ST_IDLE;
                        wu_cnt_d = '0;
                    end else if (wu_cnt_q <= WU_ONE) begin
                        // Last warm-up cycle: the next cycle is the first real sample.
                        state_d  = ST_MONITOR;
                        wu_cnt_d = '0;
                    end else begin
                        wu_cnt_d = wu_cnt_q - WU_ONE;
                    end
                end

                ST_MONITOR: begin
                    if (stop) begin
                        // The sample presented alongside stop is dropped.
                        state_d = ST_IDLE;
                    end else begin
                        sample_en = 1'b1;
                        if (eq_in) begin
                            if (match_q != CNT_MAX) begin
                                match_d = match_q + CNT_ONE;
                            end
                            run_d = '0;
                        end else begin
                            if (mismatch_q != CNT_MAX) begin
                                mismatch_d = mismatch_q + CNT_ONE;
                            end
                            if (run_q >= (RUN_MAX - 4'd1)) begin
                                run_d   = RUN_MAX;
                                state_d = ST_FAIL;
                                fail_d  = 1'b1;
                            end else begin
                                run_d = run_q + 4'd1;
                            end
                        end
                    end
                end

                ST_FAIL: begin
                    // Frozen: start, stop and eq_in have no effect here.
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wu_cnt_q   <= '0;
            match_q    <= '0;
            mismatch_q <= '0;
            run_q      <= '0;
            fail_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wu_cnt_q   <= wu_cnt_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            run_q      <= run_d;
            fail_q     <= fail_d;
            busy_q     <= busy_d;
        end
    end

    assign state        = state_q;
    assign match_cnt    = match_q;
    assign mismatch_cnt = mismatch_q;
    assign run_len      = run_q;
    assign fail         = fail_q;
    assign busy         = busy_q;

`ifdef MON_HISTORY_EN
    logic [7:0] hist_q;

    // Sample history: shifts only on cycles that were counted as samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else if (clear) begin
            hist_q <= '0;
        end else if (sample_en) begin
            hist_q <= {hist_q[6:0], eq_in};
        end
    end

    assign hist = hist_q;
`else
    // No history register in this build; the sample strobe has no consumer.
    logic unused_sample_en;
    assign unused_sample_en = sample_en;
`endif

endmodule

// File: tb/tb_compare_result_monitor.sv
// ---------------------------------------------------------------------------
// tb_compare_result_monitor
//
// Directed bench for compare_result_monitor. dut1 uses default parameters;
// dut2 uses CNT_W=4, WARMUP_CYCLES=0, FAIL_THRESH=2 to reach the saturation
// and zero-warm-up corners quickly.
// ---------------------------------------------------------------------------
module tb_compare_result_monitor;

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst_n;

    logic        start, stop, clear, eq_in;
    logic [15:0] match_cnt, mismatch_cnt;
    logic [3:0]  run_len;
    logic        fail, busy;
    logic [1:0]  state;

    logic        start2, stop2, clear2, eq2;
    logic [3:0]  match2, mismatch2;
    logic [3:0]  run2;
    logic        fail2, busy2;
    logic [1:0]  state2;

`ifdef MON_HISTORY_EN
    logic [7:0]  hist, hist2;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    int pat_b[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    int run_b[8] = '{1, 2, 3, 0, 1, 2, 3, 4};
    int pat_h[4] = '{1, 0, 1, 1};

    always #5 if (clk_run) clk = ~clk;

    compare_result_monitor dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .clear        (clear),
        .eq_in        (eq_in),
        .match_cnt    (match_cnt),
        .mismatch_cnt (mismatch_cnt),
        .run_len      (run_len),
        .fail         (fail),
        .busy         (busy),
        .state        (state)
`ifdef MON_HISTORY_EN
        ,
        .hist         (hist)
`endif
    );

    compare_result_monitor #(
        .WARMUP_CYCLES (0),
        .CNT_W         (4),
        .FAIL_THRESH   (2)
    ) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start2),
        .stop         (stop2),
        .clear        (clear2),
        .eq_in        (eq2),
        .match_cnt    (match2),
        .mismatch_cnt (mismatch2),
        .run_len      (run2),
        .fail         (fail2),
        .busy         (busy2),
        .state        (state2)
`ifdef MON_HISTORY_EN
        ,
        .hist         (hist2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        start = 0; stop = 0; clear = 0; eq_in = 0;
        start2 = 0; stop2 = 0; clear2 = 0; eq2 = 0;
        rst_n = 1'b1;

        // Asynchronous reset with the clock stopped.
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_match", 32'(match_cnt), 0);
        check("rst_mismatch", 32'(mismatch_cnt), 0);
        check("rst_run_len", 32'(run_len), 0);
        check("rst_fail", 32'(fail), 0);
        check("rst_busy", 32'(busy), 0);

        clk_run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_after_rst", 32'(state), 0);

        // Start, three warm-up cycles with eq_in=0, then matching samples.
        start = 1;
        step();
        check("wu_state_1", 32'(state), 1);
        check("wu_busy", 32'(busy), 1);
        start = 0; eq_in = 0;
        step();
        check("wu_state_2", 32'(state), 1);
        step();
        check("wu_state_3", 32'(state), 1);
        step();
        check("mon_entry_state", 32'(state), 2);
        check("wu_mismatch_ignored", 32'(mismatch_cnt), 0);
        check("wu_match_ignored", 32'(match_cnt), 0);
        eq_in = 1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("match_inc_%0d", i), 32'(match_cnt), 32'(i));
        end
        check("match_phase_mismatch", 32'(mismatch_cnt), 0);

        // Streak pattern 0,0,0,1,0,0,0,0 on top of 3 matches.
        for (int i = 0; i < 8; i++) begin
            eq_in = (pat_b[i] != 0);
            step();
            check($sformatf("run_len_%0d", i), 32'(run_len), 32'(run_b[i]));
            check($sformatf("streak_state_%0d", i), 32'(state), (i == 7) ? 32'd3 : 32'd2);
        end
        check("fail_set", 32'(fail), 1);
        check("fail_mismatch", 32'(mismatch_cnt), 7);
        check("fail_match", 32'(match_cnt), 4);

        // FAIL ignores eq_in, start and stop.
        eq_in = 1; start = 1; stop = 1;
        step();
        step();
        check("frozen_state", 32'(state), 3);
        check("frozen_match", 32'(match_cnt), 4);
        check("frozen_mismatch", 32'(mismatch_cnt), 7);
        check("frozen_run_len", 32'(run_len), 4);
        check("frozen_fail", 32'(fail), 1);

        // clear and start together in FAIL.
        stop = 0; clear = 1; start = 1;
        step();
        check("clr_state", 32'(state), 0);
        check("clr_fail", 32'(fail), 0);
        check("clr_match", 32'(match_cnt), 0);
        check("clr_mismatch", 32'(mismatch_cnt), 0);
        check("clr_run_len", 32'(run_len), 0);
        check("clr_busy", 32'(busy), 0);
        clear = 0; start = 0;
        step();
        check("clr_stays_idle", 32'(state), 0);

        // New run: samples 1,0,1,1 then 0, then stop with a discarded 0.
        start = 1;
        step();
        start = 0;
        step(); step(); step();
        check("run2_mon_state", 32'(state), 2);
        for (int i = 0; i < 4; i++) begin
            eq_in = (pat_h[i] != 0);
            step();
        end
        check("hist_pat_match", 32'(match_cnt), 3);
        check("hist_pat_mismatch", 32'(mismatch_cnt), 1);
`ifdef MON_HISTORY_EN
        check("hist_1011", 32'(hist[3:0]), 32'hB);
`endif
        eq_in = 0;
        step();
        check("pre_stop_run_len", 32'(run_len), 1);
        check("pre_stop_mismatch", 32'(mismatch_cnt), 2);
        stop = 1; eq_in = 0;
        step();
        check("stop_state", 32'(state), 0);
        check("stop_busy", 32'(busy), 0);
        check("stop_match_kept", 32'(match_cnt), 3);
        check("stop_mismatch_kept", 32'(mismatch_cnt), 2);
        stop = 0;

        // Restart accumulates counts and zeroes the streak.
        start = 1;
        step();
        check("restart_state", 32'(state), 1);
        check("restart_run_len", 32'(run_len), 0);
        check("restart_match", 32'(match_cnt), 3);
        check("restart_mismatch", 32'(mismatch_cnt), 2);
        start = 0; stop = 1;
        step();
        check("stop_in_wu_state", 32'(state), 0);
        stop = 0;

        // start while MONITOR is ignored.
        start = 1;
        step();
        start = 0;
        step(); step(); step();
        start = 1; eq_in = 1;
        step();
        check("start_in_mon_state", 32'(state), 2);
        check("start_in_mon_match", 32'(match_cnt), 4);
        start = 0;

        // clear outranks stop.
        clear = 1; stop = 1; eq_in = 0;
        step();
        check("clr_stop_state", 32'(state), 0);
        check("clr_stop_match", 32'(match_cnt), 0);
        check("clr_stop_mismatch", 32'(mismatch_cnt), 0);
        clear = 0; stop = 0;

        // Reset asserted mid-run acts without a clock edge.
        start = 1;
        step();
        start = 0;
        check("pre_rst_state", 32'(state), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_state", 32'(state), 0);
        check("midrun_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_idle", 32'(state), 0);

        // dut2: zero warm-up, 4-bit saturation, threshold of 2.
        start2 = 1;
        step();
        check("d2_direct_monitor", 32'(state2), 2);
        start2 = 0; eq2 = 1;
        repeat (15) step();
        check("d2_match_15", 32'(match2), 15);
        repeat (5) step();
        check("d2_match_sat", 32'(match2), 15);
        eq2 = 0;
        step();
        check("d2_run_1", 32'(run2), 1);
        check("d2_state_mon", 32'(state2), 2);
        step();
        check("d2_run_2", 32'(run2), 2);
        check("d2_state_fail", 32'(state2), 3);
        check("d2_fail", 32'(fail2), 1);
        check("d2_mismatch", 32'(mismatch2), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/compare_result_monitor.md
COMPARE_RESULT_MONITOR -- requirements
Module: compare_result_monitor

Interface
REQ-001 Parameter WARMUP_CYCLES, default 3, SHALL set the number of cycles after start during which eq_in is ignored while the upstream pipeline fills.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of match_cnt and mismatch_cnt.
REQ-003 Parameter FAIL_THRESH, default 4, legal range 1..15, SHALL set the number of consecutive mismatches that causes failure.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-006 start  input  1  SHALL request a monitoring run, sampled in IDLE only.
REQ-007 stop  input  1  SHALL end a run from WARMUP or MONITOR, keeping the counts.
REQ-008 clear  input  1  SHALL synchronously return the block to IDLE and zero all counts.
REQ-009 eq_in  input  1  SHALL carry the equality result from the upstream E/F compare pipeline (1 = match).
REQ-010 match_cnt  output  CNT_W  SHALL hold the number of matching samples.
REQ-011 mismatch_cnt  output  CNT_W  SHALL hold the number of mismatching samples.
REQ-012 run_len  output  4  SHALL hold the current consecutive-mismatch count.
REQ-013 fail  output  1  SHALL be the sticky failure flag.
REQ-014 busy  output  1  SHALL be high whenever state != IDLE.
REQ-015 state  output  2  SHALL expose the FSM encoding: IDLE=00, WARMUP=01, MONITOR=10, FAIL=11.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 IDLE: start=1 SHALL go to WARMUP next cycle and load the warm-up counter with WARMUP_CYCLES.
REQ-018 WARMUP: the block SHALL ignore eq_in, decrement the warm-up counter each cycle and enter MONITOR after exactly WARMUP_CYCLES cycles in WARMUP. WARMUP_CYCLES=0 SHALL go from IDLE directly to MONITOR.
REQ-019 MONITOR: eq_in SHALL be sampled every cycle; a sample of 1 SHALL increment match_cnt and zero run_len.
REQ-020 MONITOR: a sample of 0 SHALL increment mismatch_cnt and run_len.
REQ-021 When run_len reaches FAIL_THRESH, the block SHALL enter FAIL and set fail=1 on that same edge.
REQ-022 match_cnt and mismatch_cnt SHALL saturate at all-ones and never wrap.
REQ-023 run_len SHALL saturate at FAIL_THRESH.
REQ-024 FAIL SHALL be sticky: counts frozen, eq_in, start and stop ignored; the block SHALL leave FAIL only via clear or rst_n.
REQ-025 stop in WARMUP or MONITOR SHALL go to IDLE next cycle with counts retained and the eq_in sample of that cycle discarded.
REQ-026 A new start from IDLE SHALL keep the existing counts (accumulate across runs) and zero run_len.
REQ-027 Priority, highest first, SHALL be: clear, then stop, then FSM advance; start outside IDLE SHALL be ignored.
REQ-028 clear SHALL set fail=0, all counts to 0 and state to IDLE on the next edge.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, match_cnt=0, mismatch_cnt=0, run_len=0, fail=0 and busy=0, independent of clk.
REQ-030 Reset deassertion mid-run SHALL leave the block in IDLE, waiting for a new start.

Configuration
REQ-031 Macro MON_HISTORY_EN, when defined, SHALL add output hist[7:0], an 8-bit shift register of MONITOR samples (newest in bit 0, shifted only on sampled cycles, cleared by clear or rst_n).
REQ-032 Without MON_HISTORY_EN, the hist port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 rst_n low with clk stopped: all outputs 0 and state=00 without any clock edge.
REQ-034 Defaults, start pulse, then eq_in=0 for cycles 1-3 and 1 afterwards: state 01 for 3 cycles, then 10; mismatch_cnt=0; match_cnt increments once per cycle.
REQ-035 In MONITOR, eq_in pattern 0,0,0,1,0,0,0,0: run_len reads 1,2,3,0,1,2,3,4; fail=1 and state=11 on the 8th sample; mismatch_cnt=7, match_cnt=1 and both frozen afterwards.
REQ-036 CNT_W=4, 20 matching samples: match_cnt holds 15.
REQ-037 clear and start asserted together in FAIL: next cycle state=00, fail=0, all counts 0; start ignored.
REQ-038 MON_HISTORY_EN defined, samples 1,0,1,1: hist[3:0]=4'b1011; stop mid-MONITOR: state=00, counts kept.
